greater_than: RTL and testbench
===============================

# greater_than

Registered magnitude comparator for two unsigned or two's-complement operands of parameterizable width. Each accepted operand pair produces a one-hot greater/equal/less result. The block also keeps a saturating count of greater-than results. It sits in the simple combinational-logic library as the clocked, pipelinable version of the 2-bit "A greater than B" function. With WIDTH=2 and signed_mode=0, the `gt` output reproduces that function exactly.

## Interface
- WIDTH, default 2: operand width in bits, legal range 1..64.
- CNT_W, default 16: width of the greater-than counter.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, synchronous and active-low, sampled on the rising clk edge.
- in_valid  input  1: operand pair on a/b is accepted this cycle.
- a  input  WIDTH: operand A.
- b  input  WIDTH: operand B.
- signed_mode  input  1: 0 = unsigned compare, 1 = two's-complement compare; sampled with in_valid.
- cnt_clr  input  1: synchronous clear of gt_count.
- out_valid  output  1: result registers were updated from an accepted pair on the previous edge.
- gt  output  1: A > B (the F of the original function).
- eq  output  1: A == B.
- lt  output  1: A < B.
- gt_count  output  CNT_W: number of accepted pairs with A > B, saturating.

## Operation
- Unsigned mode: plain binary magnitude compare.
- Signed mode: the MSB is the sign bit.
  - If the sign bits differ, the operand with MSB=0 is greater.
  - Otherwise compare as unsigned.
- Exactly one of gt/eq/lt is high whenever out_valid=1.
- When in_valid=0, gt/eq/lt hold their previous values and out_valid goes 0 on the next edge.
- gt_count increments by 1 on each accepted pair whose result is gt.
  - It saturates at 2^CNT_W−1 and never wraps.
- cnt_clr takes priority over a simultaneous increment; gt_count becomes 0 on that edge.
- WIDTH=1 signed: value 1 represents −1, so 0 > 1 holds.

## Timing
- Latency: 1 cycle. Operands accepted at edge N appear on gt/eq/lt at edge N, with out_valid=1 in cycle N..N+1.
- Throughput: one compare per cycle; no back-pressure.
- Reset (rst_n=0 at an edge):
  - out_valid=0, gt=0, eq=0, lt=0, gt_count=0.
  - An in_valid asserted in the same cycle is discarded.
- Reset mid-stream: the in-flight result is lost; the first accepted pair after rst_n returns high produces normal output one edge later.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cmp_pkg`: result encoding constants CMP_GT/CMP_EQ/CMP_LT for the one-hot {gt,eq,lt} triple, and the default WIDTH/CNT_W values.
- One sub-module, `cmp_cell`:
  - Combines the (gt, eq) pairs of two adjacent bit groups into a parent (gt, eq), with the high group dominant.
  - The top level instantiates a generate-built tree of cmp_cell over the operand bits.
  - The MSB leaf is inverted in signed mode.
  - Followed by the result and counter registers.

## Test plan
- Exhaustive WIDTH=2 unsigned: drive {a,b} = 0..15, one per cycle.
  - gt=1 exactly for {a,b} = 4, 8, 9, 12, 13, 14.
  - eq=1 for 0, 5, 10, 15; lt=1 otherwise.
  - Final gt_count=6.
- Signed WIDTH=2: a=2'b10 (−2), b=2'b01 (+1) → lt=1. Same pair with signed_mode=0 → gt=1.
- Reset: pulse rst_n=0 for one edge with in_valid=1 → out_valid=0, gt/eq/lt=0, gt_count=0. Next accepted pair a=3, b=0 → gt=1 one edge later.
- Hold: in_valid=0 for 3 cycles after a=1, b=2 → lt stays 1, out_valid=0, gt_count unchanged.
- Saturation and clear: CNT_W=2, six gt pairs → gt_count=3. cnt_clr asserted together with a gt pair → gt_count=0.
- WIDTH=8 random: 1000 random pairs in each mode, checked against a reference model; one-hot invariant holds on every out_valid cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the registered magnitude comparator.
package cmp_pkg;

  // Default block geometry.
  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_CNT_W = 16;

  // One-hot {gt, eq, lt} result encodings.
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // Map a resolved (gt, eq) pair onto the one-hot result triple.
  function automatic logic [2:0] cmp_encode(input logic gt, input logic eq);
    if (gt)      return CMP_GT;
    else if (eq) return CMP_EQ;
    else         return CMP_LT;
  endfunction

endpackage

// File: rtl/cmp_cell.sv
// Merges the (gt, eq) status of two adjacent bit groups into the status of
// their concatenation. The high group decides unless it is equal.
module cmp_cell (
  input  logic hi_gt,
  input  logic hi_eq,
  input  logic lo_gt,
  input  logic lo_eq,
  output logic gt,
  output logic eq
);

  assign gt = hi_gt | (hi_eq & lo_gt);
  assign eq = hi_eq & lo_eq;

endmodule

// File: rtl/greater_than.sv
// Registered magnitude comparator: a balanced tree of cmp_cell resolves
// a vs b, then one register stage holds the one-hot result, a valid flag and
// a saturating count of greater-than results.
module greater_than
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] gt_count
);

  // Leaves are padded up to a power of two; padding leaves read as "equal"
  // so they never influence the result.
  localparam int LEAVES = 1 << $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Heap-ordered tree: node k has children 2k (low half) and 2k+1 (high
  // half); leaf for bit i sits at LEAVES+i; the root is node 1.
  logic [2*LEAVES-1:1] node_gt;
  logic [2*LEAVES-1:1] node_eq;

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi >= WIDTH) begin : g_pad
        assign node_gt[LEAVES+gi] = 1'b0;
        assign node_eq[LEAVES+gi] = 1'b1;
      end else if (gi == WIDTH - 1) begin : g_msb
        // In signed mode a set sign bit means smaller, so the MSB leaf flips.
        assign node_gt[LEAVES+gi] = signed_mode ? (~a[gi] & b[gi]) : (a[gi] & ~b[gi]);
        assign node_eq[LEAVES+gi] = a[gi] ~^ b[gi];
      end else begin : g_bit
        assign node_gt[LEAVES+gi] = a[gi] & ~b[gi];
        assign node_eq[LEAVES+gi] = a[gi] ~^ b[gi];
      end
    end

    for (gi = 1; gi < LEAVES; gi++) begin : g_node
      cmp_cell u_cell (
        .hi_gt (node_gt[2*gi+1]),
        .hi_eq (node_eq[2*gi+1]),
        .lo_gt (node_gt[2*gi]),
        .lo_eq (node_eq[2*gi]),
        .gt    (node_gt[gi]),
        .eq    (node_eq[gi])
      );
    end
  endgenerate

  logic [2:0] result;
  assign result = cmp_encode(node_gt[1], node_eq[1]);

  // Result registers: capture on accepted pairs, hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it is just the highest
    // priority branch, and an in_valid in the same cycle is dropped.
    if (!rst_n) begin
      out_valid     <= 1'b0;
      {gt, eq, lt}  <= 3'b000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {gt, eq, lt} <= result;
      end
    end
  end

  // Saturating greater-than counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_count <= '0;
    end else if (cnt_clr) begin
      gt_count <= '0;
    end else if (in_valid && node_gt[1] && (gt_count != CNT_MAX)) begin
      gt_count <= gt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_greater_than.sv
// Self-checking bench for greater_than. Four instances cover WIDTH=2
// (default counter), WIDTH=2 with a 2-bit counter, WIDTH=8 and WIDTH=1.
// An integer-arithmetic model tracks every instance and is compared each
// cycle; directed literal checks pin the model.
module tb_greater_than;

  localparam int N = 4;
  localparam int WID [N] = '{2, 2, 8, 1};
  localparam longint CMAX [N] = '{65535, 3, 65535, 65535};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [N-1:0] in_valid, smode, clr;
  logic [7:0] a_v [N];
  logic [7:0] b_v [N];

  logic [N-1:0] ov, og, oe, ol;
  logic [15:0] cnt0, cnt2, cnt3;
  logic [1:0]  cnt1;
  logic [15:0] oc [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  greater_than #(.WIDTH(2), .CNT_W(16)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .a(a_v[0][1:0]), .b(b_v[0][1:0]),
    .signed_mode(smode[0]), .cnt_clr(clr[0]), .out_valid(ov[0]), .gt(og[0]), .eq(oe[0]),
    .lt(ol[0]), .gt_count(cnt0));

  greater_than #(.WIDTH(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .a(a_v[1][1:0]), .b(b_v[1][1:0]),
    .signed_mode(smode[1]), .cnt_clr(clr[1]), .out_valid(ov[1]), .gt(og[1]), .eq(oe[1]),
    .lt(ol[1]), .gt_count(cnt1));

  greater_than #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .a(a_v[2]), .b(b_v[2]),
    .signed_mode(smode[2]), .cnt_clr(clr[2]), .out_valid(ov[2]), .gt(og[2]), .eq(oe[2]),
    .lt(ol[2]), .gt_count(cnt2));

  greater_than #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .a(a_v[3][0:0]), .b(b_v[3][0:0]),
    .signed_mode(smode[3]), .cnt_clr(clr[3]), .out_valid(ov[3]), .gt(og[3]), .eq(oe[3]),
    .lt(ol[3]), .gt_count(cnt3));

  always_comb begin
    oc[0] = cnt0;
    oc[1] = {14'd0, cnt1};
    oc[2] = cnt2;
    oc[3] = cnt3;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference compare from integer values: 2 = gt, 1 = eq, 0 = lt.
  function automatic int ref_cmp(input logic [7:0] a, input logic [7:0] b,
                                 input int w, input bit s);
    longint span, va, vb;
    span = longint'(1) << w;
    va = longint'(a) % span;
    vb = longint'(b) % span;
    if (s && va >= span / 2) va -= span;
    if (s && vb >= span / 2) vb -= span;
    if (va > vb)  return 2;
    if (va == vb) return 1;
    return 0;
  endfunction

  // Behavioural model state.
  bit     armed = 1'b0;
  bit     m_valid [N];
  int     m_res   [N];
  bit     m_any   [N];
  longint m_cnt   [N];

  // Model update on every edge, then compare all instances 1 time unit later.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_valid[i] = 1'b0;
        m_any[i]   = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        int r;
        r = ref_cmp(a_v[i], b_v[i], WID[i], smode[i]);
        m_valid[i] = in_valid[i];
        if (in_valid[i]) begin
          m_res[i] = r;
          m_any[i] = 1'b1;
        end
        if (clr[i]) m_cnt[i] = 0;
        else if (in_valid[i] && r == 2 && m_cnt[i] < CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (!rst_n) armed = 1'b1;
    if (armed) begin
      #1;
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_valid[%0d]", i), longint'(ov[i]), longint'(m_valid[i]));
        check($sformatf("model_gt[%0d]", i), longint'(og[i]), longint'(m_any[i] && m_res[i] == 2));
        check($sformatf("model_eq[%0d]", i), longint'(oe[i]), longint'(m_any[i] && m_res[i] == 1));
        check($sformatf("model_lt[%0d]", i), longint'(ol[i]), longint'(m_any[i] && m_res[i] == 0));
        check($sformatf("model_cnt[%0d]", i), longint'(oc[i]), m_cnt[i]);
        if (ov[i]) check($sformatf("onehot[%0d]", i), longint'(og[i]) + oe[i] + ol[i], 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    smode    = '0;
    clr      = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    step();
    step();
    check("reset_valid", ov[0], 0);
    check("reset_gt", og[0], 0);
    check("reset_cnt", cnt0, 0);

    // Exhaustive WIDTH=2 unsigned sweep.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      @(negedge clk);
      in_valid[0] = 1'b1;
      a_v[0] = {6'd0, kv[3:2]};
      b_v[0] = {6'd0, kv[1:0]};
      step();
      check($sformatf("exh_gt[%0d]", k), og[0],
            (k == 4 || k == 8 || k == 9 || k == 12 || k == 13 || k == 14) ? 1 : 0);
      check($sformatf("exh_eq[%0d]", k), oe[0],
            (k == 0 || k == 5 || k == 10 || k == 15) ? 1 : 0);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    step();
    check("exh_count", cnt0, 6);

    // Signed WIDTH=2: -2 vs +1, then same bits unsigned.
    @(negedge clk);
    in_valid[0] = 1'b1; a_v[0] = 8'd2; b_v[0] = 8'd1; smode[0] = 1'b1;
    step();
    check("signed_lt", ol[0], 1);
    @(negedge clk);
    smode[0] = 1'b0;
    step();
    check("unsigned_gt", og[0], 1);

    // Hold: a=1, b=2 then three idle cycles.
    @(negedge clk);
    a_v[0] = 8'd1; b_v[0] = 8'd2;
    step();
    check("hold_lt0", ol[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_lt", ol[0], 1);
      check("hold_valid", ov[0], 0);
      check("hold_cnt", cnt0, 7);
    end

    // Reset pulse with in_valid high discards the pair.
    @(negedge clk);
    rst_n = 1'b0; in_valid[0] = 1'b1; a_v[0] = 8'd3; b_v[0] = 8'd0;
    step();
    check("rst_valid", ov[0], 0);
    check("rst_gt", og[0], 0);
    check("rst_eq", oe[0], 0);
    check("rst_lt", ol[0], 0);
    check("rst_cnt", cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_gt", og[0], 1);
    check("post_rst_valid", ov[0], 1);
    check("post_rst_cnt", cnt0, 1);
    @(negedge clk);
    in_valid[0] = 1'b0;

    // Saturation on a 2-bit counter, then clear against a gt pair.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid[1] = 1'b1; a_v[1] = 8'd3; b_v[1] = 8'd1;
      step();
    end
    check("sat_cnt", cnt1, 3);
    @(negedge clk);
    clr[1] = 1'b1;
    step();
    check("clr_cnt", cnt1, 0);
    check("clr_gt", og[1], 1);
    @(negedge clk);
    clr[1] = 1'b0;
    step();
    check("after_clr_cnt", cnt1, 1);
    @(negedge clk);
    in_valid[1] = 1'b0;

    // WIDTH=1: signed 0 > 1 (-1), unsigned 0 < 1.
    @(negedge clk);
    in_valid[3] = 1'b1; a_v[3] = 8'd0; b_v[3] = 8'd1; smode[3] = 1'b1;
    step();
    check("w1_signed_gt", og[3], 1);
    @(negedge clk);
    smode[3] = 1'b0;
    step();
    check("w1_unsigned_lt", ol[3], 1);
    @(negedge clk);
    in_valid[3] = 1'b0;

    // WIDTH=8 random: 1000 pairs unsigned, 1000 signed, occasional gaps/clears.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      in_valid[2] = ($urandom_range(0, 15) != 0);
      smode[2]    = (n >= 1000);
      clr[2]      = ($urandom_range(0, 63) == 0);
      a_v[2]      = 8'($urandom);
      b_v[2]      = ($urandom_range(0, 7) == 0) ? a_v[2] : 8'($urandom);
    end
    @(negedge clk);
    in_valid = '0;
    clr      = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
